herm_frame_builder: RTL and testbench
=====================================

Name: herm_frame_builder

Overview:
- Parametrised streaming successor to the OFDM Tx Hermitian buffer.
- Accepts N_ACT complex mapper symbols per OFDM symbol on a valid/ready stream.
- Emits N_FFT-sample Hermitian-symmetric frames (DC zero, data, zero padding, mirrored conjugate) to the IFFT input, so the IFFT output is real-valued for VLC.
- Uses a ping-pong symbol store, so input fill and output emission overlap; no full-burst store and no tx_done reset.

Parameters:
DW, 8, width of each I/Q component (two's complement)
N_FFT, 64, IFFT size in samples per OFDM symbol
N_ACT, 28, active data subcarriers per symbol; must satisfy 2*N_ACT+1 <= N_FFT
N_SYM, 8, OFDM symbols per burst; sets m_burst_last
AW, clog2(N_FFT), width of the internal sample index

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
s_data  in  2*DW  mapper symbol; [2*DW-1:DW]=Q (imag), [DW-1:0]=I (real)
s_valid  in  1  s_data valid
s_ready  out  1  block can accept s_data this cycle
m_data  out  2*DW  IFFT input sample, same packing as s_data
m_valid  out  1  m_data valid
m_ready  in  1  IFFT accepts m_data
m_sym_last  out  1  high with the last sample (index N_FFT-1) of each symbol
m_burst_last  out  1  high with the last sample of symbol N_SYM-1 of the burst
sym_idx  out  clog2(N_SYM)  index of the symbol currently being emitted
ovf_sat  out  1  sticky flag: a conjugate saturated; cleared only by rst

Behaviour:
- Reset values: s_ready=0 during rst, 1 on the first cycle after. m_valid=0, m_data=0, m_sym_last=0, m_burst_last=0, sym_idx=0, ovf_sat=0. Both banks are empty and all counters are 0.
- Reset mid-operation discards partial fills and partial emissions. The next accepted input is X[0] of symbol 0.

Storage:
- Two banks (A/B) of N_ACT entries each. Each bank has a full flag.
- Write side fills wr_bank; read side drains rd_bank. Both start at A.

Input side:
- s_ready = !full[wr_bank].
- On s_valid&&s_ready: bank[wr_bank][wr_cnt] <= s_data; wr_cnt++.
- At wr_cnt==N_ACT-1 the write sets full[wr_bank], clears wr_cnt and toggles wr_bank.

Output state machine:
- States: IDLE, EMIT.
- IDLE -> EMIT when full[rd_bank]=1; n=0.
- In EMIT, n advances on each output handshake (m_valid&&m_ready).

Output sample n of a symbol:
- n=0: 0 (DC).
- 1..N_ACT: X[n-1].
- N_ACT+1..N_FFT-N_ACT-1: 0.
- N_FFT-N_ACT..N_FFT-1: conj(X[N_FFT-1-n]).
- Example: n=N_FFT-1 gives conj X[0].

Conjugate:
- I unchanged; Q' = -Q.
- Q=-2^(DW-1) saturates to 2^(DW-1)-1 and sets ovf_sat.

Output register and backpressure:
- Output is registered.
- While m_valid&&!m_ready, m_data, m_sym_last, m_burst_last and sym_idx hold stable.
- A new sample is presented the cycle after each handshake. No bubbles are allowed while the bank is full and m_ready=1 (one sample per clock sustained).

End of symbol:
- The handshake at n=N_FFT-1 clears full[rd_bank] and toggles rd_bank.
- sym_idx wraps N_SYM-1 -> 0.
- If the other bank is already full, the next symbol's n=0 follows with no gap; otherwise go to IDLE and drop m_valid.

Timing:
- Latency from the handshake of X[N_ACT-1] to the first m_valid: 2 cycles.
- Same-cycle events: a bank's full set (write) and its clear (read) never target the same bank. A write-completion and a read-completion in the same cycle on opposite banks are both honoured.
- Throughput: input needs N_ACT cycles/symbol and output N_FFT, so s_ready deasserts periodically. This is expected.

Test Plan:
- Single symbol: DW=8, N_FFT=64, N_ACT=28, N_SYM=2. Feed X[k]={Q=k,I=k+1}, k=0..27, m_ready=1. Required output:
  - n0=0x0000; n1=0x0001; n28=0x1B1C.
  - n29..n35=0.
  - n36 = {Q=-27,I=28} = 0xE51C; n63 = 0x0001.
  - m_sym_last at n63 only; first m_valid 2 cycles after X[27].
- Burst: 2 symbols back-to-back with s_valid=1 always. Required:
  - 128 output samples, no gaps after the first.
  - m_burst_last only at sample 127; sym_idx 0 then 1.
  - s_ready low whenever both banks are full.
- Backpressure: m_ready toggled pseudo-randomly. Required: m_data/flags stable while stalled; the sequence is identical to the m_ready=1 case.
- Saturation: X[5]={Q=0x80,I=0x10}. Required: n58=0x7F10 and ovf_sat=1, held until rst.
- Input stall: s_valid low for 10 cycles mid-symbol. Required: no output for that symbol until X[27] is accepted; data still correct.
- Mid-operation reset: rst after 40 output samples. Required:
  - The next cycle has m_valid=0 and s_ready=1.
  - A fresh symbol emits from n=0 with sym_idx=0 and no stale data.

Source files
------------

// File: rtl/herm_frame_builder.sv
// herm_frame_builder
//   Collects N_ACT complex mapper symbols per OFDM symbol and emits one
//   N_FFT-sample Hermitian-symmetric frame per symbol to the IFFT, so the
//   IFFT output is real-valued:
//     n = 0                       : 0 (DC)
//     n = 1 .. N_ACT              : X[n-1]
//     n = N_ACT+1 .. N_FFT-N_ACT-1: 0
//     n = N_FFT-N_ACT .. N_FFT-1  : conj(X[N_FFT-1-n])
//   Two symbol banks (ping-pong) let the next symbol fill while the current
//   one is emitted. The output is fully registered.
//   The parameters must satisfy 2*N_ACT+1 <= N_FFT.
//
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   s_data/s_valid/s_ready : mapper input stream, {Q, I} two's complement
//   m_data/m_valid/m_ready : IFFT sample stream, same packing
//   m_sym_last           : with sample N_FFT-1 of every symbol
//   m_burst_last         : with sample N_FFT-1 of symbol N_SYM-1
//   sym_idx              : index of the symbol being emitted (wraps at N_SYM)
//   ovf_sat              : sticky, a conjugate Q component saturated
module herm_frame_builder #(
  parameter int DW    = 8,
  parameter int N_FFT = 64,
  parameter int N_ACT = 28,
  parameter int N_SYM = 8,
  parameter int AW    = $clog2(N_FFT),
  parameter int SW    = (N_SYM > 1) ? $clog2(N_SYM) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2*DW-1:0] s_data,
  input  logic            s_valid,
  output logic            s_ready,
  output logic [2*DW-1:0] m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_sym_last,
  output logic            m_burst_last,
  output logic [SW-1:0]   sym_idx,
  output logic            ovf_sat
);

  localparam int CW = (N_ACT > 1) ? $clog2(N_ACT) : 1;
  localparam logic signed [DW-1:0] Q_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] Q_MAX = {1'b0, {(DW-1){1'b1}}};

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  // Conjugate with saturation: the negation of the most negative Q does not
  // fit, so it clips to the most positive value. Bit 2*DW flags the clip.
  function automatic logic [2*DW:0] conj_sat(input logic [2*DW-1:0] x);
    logic signed [DW-1:0] q;
    logic signed [DW-1:0] q_neg;
    q     = x[2*DW-1:DW];
    q_neg = -q;
    if (q == Q_MIN) begin
      return {1'b1, Q_MAX, x[DW-1:0]};
    end
    return {1'b0, q_neg, x[DW-1:0]};
  endfunction

  // Symbol storage (data only, never reset)
  logic [2*DW-1:0] mem_q [2][N_ACT];
  logic [2*DW-1:0] mem_d [2][N_ACT];

  // Control state
  state_t          state_q, state_d;
  logic [1:0]      full_q, full_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]   n_q, n_d;
  logic [SW-1:0]   sym_idx_q, sym_idx_d;
  logic            ovf_sat_q, ovf_sat_d;

  // Output register
  logic            m_valid_q, m_valid_d;
  logic [2*DW-1:0] m_data_q, m_data_d;
  logic            m_sym_last_q, m_sym_last_d;
  logic            m_burst_last_q, m_burst_last_d;

  // Sample generator
  logic            load;
  logic [AW-1:0]   ld_n;
  logic [2*DW-1:0] samp;
  logic            samp_sat;
  logic [CW-1:0]   rd_idx;
  int              ni;

  logic            s_acc;
  logic            m_hs;

  // Held low through reset; afterwards ready whenever the fill bank is free.
  assign s_ready = !rst && !full_q[wr_bank_q];
  assign s_acc   = s_valid && s_ready;
  assign m_hs    = m_valid_q && m_ready;

  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign m_sym_last   = m_sym_last_q;
  assign m_burst_last = m_burst_last_q;
  assign sym_idx      = sym_idx_q;
  assign ovf_sat      = ovf_sat_q;

  // Frame sample ld_n taken from the read bank. Index 0 is always DC = 0,
  // so a symbol's first sample does not depend on which bank is selected.
  always_comb begin
    samp     = '0;
    samp_sat = 1'b0;
    rd_idx   = '0;
    ni       = int'(ld_n);
    if (ni >= 1 && ni <= N_ACT) begin
      rd_idx = CW'(ni - 1);
      samp   = mem_q[rd_bank_q][rd_idx];
    end else if (ni >= N_FFT - N_ACT) begin
      rd_idx             = CW'(N_FFT - 1 - ni);
      {samp_sat, samp}   = conj_sat(mem_q[rd_bank_q][rd_idx]);
    end
  end

  always_comb begin
    mem_d          = mem_q;
    state_d        = state_q;
    full_d         = full_q;
    wr_bank_d      = wr_bank_q;
    rd_bank_d      = rd_bank_q;
    wr_cnt_d       = wr_cnt_q;
    n_d            = n_q;
    sym_idx_d      = sym_idx_q;
    ovf_sat_d      = ovf_sat_q;
    m_valid_d      = m_valid_q;
    m_data_d       = m_data_q;
    m_sym_last_d   = m_sym_last_q;
    m_burst_last_d = m_burst_last_q;
    load           = 1'b0;
    ld_n           = '0;

    // Fill side
    if (s_acc) begin
      mem_d[wr_bank_q][wr_cnt_q] = s_data;
      if (wr_cnt_q == CW'(N_ACT - 1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_cnt_d          = '0;
        wr_bank_d         = !wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + CW'(1);
      end
    end

    // Emit side: n_q is the index of the sample held in the output register
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          load    = 1'b1;
          ld_n    = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (m_hs) begin
          if (n_q == AW'(N_FFT - 1)) begin
            // The read bank is never the bank being filled, so this clear
            // cannot collide with the fill-side set above.
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
            sym_idx_d         = (sym_idx_q == SW'(N_SYM - 1)) ? '0 : sym_idx_q + SW'(1);
            if (full_q[!rd_bank_q]) begin
              load = 1'b1;
              ld_n = '0;
            end else begin
              state_d        = IDLE;
              m_valid_d      = 1'b0;
              m_data_d       = '0;
              m_sym_last_d   = 1'b0;
              m_burst_last_d = 1'b0;
            end
          end else begin
            load = 1'b1;
            ld_n = n_q + AW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      n_d            = ld_n;
      m_valid_d      = 1'b1;
      m_data_d       = samp;
      m_sym_last_d   = (ld_n == AW'(N_FFT - 1));
      m_burst_last_d = (ld_n == AW'(N_FFT - 1)) && (sym_idx_d == SW'(N_SYM - 1));
      if (samp_sat) begin
        ovf_sat_d = 1'b1;
      end
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      full_q         <= '0;
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b0;
      wr_cnt_q       <= '0;
      n_q            <= '0;
      sym_idx_q      <= '0;
      ovf_sat_q      <= 1'b0;
      m_valid_q      <= 1'b0;
      m_data_q       <= '0;
      m_sym_last_q   <= 1'b0;
      m_burst_last_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      full_q         <= full_d;
      wr_bank_q      <= wr_bank_d;
      rd_bank_q      <= rd_bank_d;
      wr_cnt_q       <= wr_cnt_d;
      n_q            <= n_d;
      sym_idx_q      <= sym_idx_d;
      ovf_sat_q      <= ovf_sat_d;
      m_valid_q      <= m_valid_d;
      m_data_q       <= m_data_d;
      m_sym_last_q   <= m_sym_last_d;
      m_burst_last_q <= m_burst_last_d;
    end
  end

endmodule

// File: tb/tb_herm_frame_builder.sv
module tb_herm_frame_builder;
  localparam int DW    = 8;
  localparam int N_FFT = 64;
  localparam int N_ACT = 28;
  localparam int N_SYM = 2;
  localparam int SW    = 1;
  localparam int SYMB  = N_ACT * 2 * DW;

  logic            clk = 1'b0;
  logic            rst;
  logic [2*DW-1:0] s_data;
  logic            s_valid;
  logic            s_ready;
  logic [2*DW-1:0] m_data;
  logic            m_valid;
  logic            m_ready;
  logic            m_sym_last;
  logic            m_burst_last;
  logic [SW-1:0]   sym_idx;
  logic            ovf_sat;

  always #5 clk = ~clk;

  herm_frame_builder #(.DW(DW), .N_FFT(N_FFT), .N_ACT(N_ACT), .N_SYM(N_SYM)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_sym_last(m_sym_last), .m_burst_last(m_burst_last),
    .sym_idx(sym_idx), .ovf_sat(ovf_sat)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: accepted symbols awaiting emission and their fill cycle
  logic [2*DW-1:0] src_q[$];
  logic [SYMB-1:0] sym_q[$];
  int              fill_q[$];
  logic [SYMB-1:0] cur_sym;
  int              cur_cnt = 0;
  int              n_exp = 0;
  int              sym_exp = 0;
  bit              ovf_exp = 0;

  // Stimulus knobs
  bit   sv_en = 1, sv_rand = 0, mr_rand = 0;
  logic mr_fixed = 1'b1;

  // Capture of every output handshake of the current test
  logic [2*DW-1:0] cap_d[256];
  bit              cap_sl[256];
  bit              cap_bl[256];
  logic [SW-1:0]   cap_si[256];
  int              cap_cyc[256];
  int              cap_n = 0;

  bit              prev_stall = 0;
  logic [2*DW-1:0] prev_d;
  logic            prev_sl, prev_bl;
  logic [SW-1:0]   prev_si;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame sample n built from the Hermitian rule: F[k]=X[k-1] for 1..N_ACT,
  // F[N_FFT-k]=conj(F[k]), everything else zero.
  function automatic logic [2*DW-1:0] ref_sample(input logic [SYMB-1:0] sym, input int n,
                                                  output bit sat);
    logic [2*DW-1:0] x;
    logic [DW-1:0]   qb;
    int k, qi, qn;
    sat = 0;
    if (n == 0) return '0;
    if (n <= N_ACT) return sym[(n-1)*2*DW +: 2*DW];
    k = N_FFT - n;
    if (k >= 1 && k <= N_ACT) begin
      x  = sym[(k-1)*2*DW +: 2*DW];
      qi = $signed(x[2*DW-1:DW]);
      qn = -qi;
      if (qn > 2**(DW-1) - 1) begin
        qn  = 2**(DW-1) - 1;
        sat = 1;
      end
      qb = qn[DW-1:0];
      return {qb, x[DW-1:0]};
    end
    return '0;
  endfunction

  task automatic check_outputs();
    bit              vexp, sat;
    logic [2*DW-1:0] e;
    vexp = 0;
    if (!rst && sym_q.size() > 0) vexp = (cyc > fill_q[0]);
    chk("s_ready", s_ready, !rst && (sym_q.size() < 2));
    chk("m_valid", m_valid, vexp);
    if (m_valid && vexp) begin
      e = ref_sample(sym_q[0], n_exp, sat);
      if (sat) ovf_exp = 1;
      chk("m_data", m_data, e);
      chk("m_sym_last", m_sym_last, n_exp == N_FFT - 1);
      chk("m_burst_last", m_burst_last, (n_exp == N_FFT - 1) && (sym_exp == N_SYM - 1));
      chk("sym_idx", sym_idx, sym_exp);
    end
    if (prev_stall) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_data", m_data, prev_d);
      chk("stall_sym_last", m_sym_last, prev_sl);
      chk("stall_burst_last", m_burst_last, prev_bl);
      chk("stall_sym_idx", sym_idx, prev_si);
    end
    chk("ovf_sat", ovf_sat, ovf_exp);
  endtask

  task automatic tick();
    bit              in_hs, out_hs;
    logic [2*DW-1:0] din;
    s_valid = sv_en && (src_q.size() > 0) && (!sv_rand || $urandom_range(0, 3) != 0);
    s_data  = (src_q.size() > 0) ? src_q[0] : '0;
    m_ready = mr_rand ? 1'($urandom_range(0, 1)) : mr_fixed;
    #1;
    din        = s_data;
    in_hs      = s_valid && s_ready && !rst;
    out_hs     = m_valid && m_ready && !rst;
    prev_stall = m_valid && !m_ready && !rst;
    prev_d     = m_data;
    prev_sl    = m_sym_last;
    prev_bl    = m_burst_last;
    prev_si    = sym_idx;
    if (out_hs && cap_n < 256) begin
      cap_d[cap_n]   = m_data;
      cap_sl[cap_n]  = m_sym_last;
      cap_bl[cap_n]  = m_burst_last;
      cap_si[cap_n]  = sym_idx;
      cap_cyc[cap_n] = cyc;
      cap_n++;
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      sym_q.delete();
      fill_q.delete();
      cur_cnt = 0;
      n_exp   = 0;
      sym_exp = 0;
      ovf_exp = 0;
    end else begin
      if (in_hs) begin
        void'(src_q.pop_front());
        cur_sym[cur_cnt*2*DW +: 2*DW] = din;
        cur_cnt++;
        if (cur_cnt == N_ACT) begin
          sym_q.push_back(cur_sym);
          fill_q.push_back(cyc);
          cur_cnt = 0;
        end
      end
      if (out_hs) begin
        n_exp++;
        if (n_exp == N_FFT) begin
          void'(sym_q.pop_front());
          void'(fill_q.pop_front());
          n_exp   = 0;
          sym_exp = (sym_exp + 1) % N_SYM;
        end
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_idle(input int max);
    int g = 0;
    while ((src_q.size() > 0 || sym_q.size() > 0 || cur_cnt > 0 || m_valid) && g < max) begin
      tick();
      g++;
    end
    chk("run_timeout", g < max, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_q.delete();
    tick();
    rst = 1'b0;
    tick();
    cap_n = 0;
  endtask

  task automatic push_rand_symbol(input bit avoid_min_q);
    logic [DW-1:0] q, i;
    for (int k = 0; k < N_ACT; k++) begin
      q = DW'($urandom);
      i = DW'($urandom);
      if (avoid_min_q && q == 8'h80) q = 8'h7F;
      src_q.push_back({q, i});
    end
  endtask

  initial begin
    int cnt, g;
    logic [2*DW-1:0] x0;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; cur_sym = '0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_m_valid", m_valid, 0);
    chk("reset_m_data", m_data, 0);
    chk("reset_sym_last", m_sym_last, 0);
    chk("reset_burst_last", m_burst_last, 0);
    chk("reset_sym_idx", sym_idx, 0);
    chk("reset_ovf", ovf_sat, 0);
    chk("reset_s_ready", s_ready, 1);

    // Single symbol, X[k] = {Q=k, I=k+1}
    cap_n = 0;
    for (int k = 0; k < N_ACT; k++) src_q.push_back({8'(k), 8'(k + 1)});
    run_idle(400);
    chk("single_count", cap_n, 64);
    chk("single_n0", cap_d[0], 16'h0000);
    chk("single_n1", cap_d[1], 16'h0001);
    chk("single_n28", cap_d[28], 16'h1B1C);
    for (int n = 29; n <= 35; n++) chk("single_pad", cap_d[n], 16'h0000);
    chk("single_n36", cap_d[36], 16'hE51C);
    chk("single_n63", cap_d[63], 16'h0001);
    cnt = 0;
    for (int n = 0; n < 64; n++) cnt += cap_sl[n];
    chk("single_sym_last_count", cnt, 1);
    chk("single_sym_last_n63", cap_sl[63], 1);

    // Burst of N_SYM back-to-back symbols
    do_reset();
    push_rand_symbol(0);
    push_rand_symbol(0);
    run_idle(600);
    chk("burst_count", cap_n, 128);
    cnt = 0;
    for (int n = 0; n < 128; n++) cnt += cap_bl[n];
    chk("burst_last_count", cnt, 1);
    chk("burst_last_127", cap_bl[127], 1);
    chk("burst_sym_idx0", cap_si[0], 0);
    chk("burst_sym_idx63", cap_si[63], 0);
    chk("burst_sym_idx64", cap_si[64], 1);
    chk("burst_no_gap", cap_cyc[127] - cap_cyc[0], 127);

    // Backpressure with random input pacing
    do_reset();
    mr_rand = 1; sv_rand = 1;
    push_rand_symbol(0);
    push_rand_symbol(0);
    push_rand_symbol(0);
    run_idle(3000);
    mr_rand = 0; sv_rand = 0;
    chk("bp_count", cap_n, 192);

    // Saturating conjugate
    do_reset();
    for (int k = 0; k < N_ACT; k++) begin
      if (k == 5) src_q.push_back(16'h8010);
      else src_q.push_back({8'($urandom_range(0, 126)), 8'($urandom)});
    end
    run_idle(400);
    chk("sat_n58", cap_d[58], 16'h7F10);
    chk("sat_ovf", ovf_sat, 1);
    repeat (5) tick();
    chk("sat_ovf_held", ovf_sat, 1);
    do_reset();
    chk("sat_ovf_cleared", ovf_sat, 0);

    // Input stall mid-symbol
    push_rand_symbol(0);
    g = 0;
    while (cur_cnt < 14 && g < 100) begin tick(); g++; end
    chk("stall_fill_timeout", g < 100, 1);
    sv_en = 0;
    repeat (10) tick();
    chk("stall_no_output", m_valid, 0);
    sv_en = 1;
    run_idle(400);
    chk("stall_count", cap_n, 64);

    // Reset in the middle of emission
    do_reset();
    push_rand_symbol(0);
    push_rand_symbol(0);
    push_rand_symbol(0);
    g = 0;
    while (cap_n < 40 && g < 400) begin tick(); g++; end
    chk("midrst_reach40", cap_n >= 40, 1);
    rst = 1'b1;
    src_q.delete();
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_s_ready", s_ready, 1);
    cap_n = 0;
    push_rand_symbol(0);
    x0 = src_q[0];
    run_idle(400);
    chk("midrst_count", cap_n, 64);
    chk("midrst_sym_idx", cap_si[0], 0);
    chk("midrst_n0", cap_d[0], 16'h0000);
    chk("midrst_n1", cap_d[1], x0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
